debug_led_scanner: RTL and testbench

Parametrised debug display controller that presents NUM_CH seven-segment channels, each with its digit-select bit, on one LED bank. It sequences through the channels automatically on a dwell timer or manually on a step pulse. It can freeze a snapshot of all channels for inspection, and flags channels whose value changed since they were last shown. It sits between the 7-segment drivers' pattern/select outputs and the board LEDs LD.

---
 rtl/debug_disp_pkg.sv | 24 ++
 rtl/debug_dwell_timer.sv | 32 +++
 rtl/debug_led_scanner.sv | 136 +++++++++++++
 tb/tb_debug_led_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_disp_pkg.sv
// Shared definitions for the debug display blocks: word/index widths,
// the blank LED pattern and the LED source selector.
package debug_disp_pkg;

   // LED word is the segment pattern plus its digit-select bit on top.
   function automatic int led_width(input int seg_w);
      return seg_w + 1;
   endfunction

   // Width of an index able to address n channels (never narrower than 1).
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // All-off LED pattern; slice to the width in use.
   localparam logic [63:0] BLANK_PATTERN = '0;

   // Where the LED bank takes its data from.
   typedef enum logic {
      SRC_LIVE = 1'b0,
      SRC_SNAP = 1'b1
   } ld_src_e;

endpackage

// File: rtl/debug_dwell_timer.sv
// Dwell prescaler: counts enabled cycles and flags the last one of each
// DWELL_CYCLES period. Clear has priority over enable.
module debug_dwell_timer #(
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int CNT_W        = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Count enabled cycles; clear restarts the period, disable holds it.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   // Terminal count only while counting, so a held counter never fires.
   always_comb begin
      tc = en && (count == LAST);
   end

endmodule

// File: rtl/debug_led_scanner.sv
// Debug LED scanner: steps through NUM_CH seven-segment channels (auto dwell
// or manual step), shows {sel, seg} of the current one on LD, can freeze a
// snapshot of all channels and flags channels that changed while hidden.
module debug_led_scanner
   import debug_disp_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int SEG_W        = 7,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int IDX_W        = idx_width(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*SEG_W-1:0] seg_in,
   input  logic [NUM_CH-1:0]       sel_in,
   input  logic                    auto_mode,
   input  logic                    step,
   input  logic                    freeze,
   output logic [SEG_W:0]          LD,
   output logic [IDX_W-1:0]        ch_idx,
   output logic                    chg
);

   localparam int LED_W = led_width(SEG_W);

   // Input register stage
   logic [LED_W-1:0]  word_q    [NUM_CH];
   logic [LED_W-1:0]  word_prev [NUM_CH];
   logic              auto_q;
   logic              step_q;
   logic              freeze_q;

   // Snapshot bank and freeze edge detector
   logic [LED_W-1:0]  snap [NUM_CH];
   logic              freeze_d;
   logic              freeze_rise;

   // Scan control and change tracking
   logic              dwell_tc;
   logic              adv;
   logic [IDX_W-1:0]  idx_nxt;
   logic [NUM_CH-1:0] changed;
   logic [NUM_CH-1:0] changed_nxt;
   logic [NUM_CH-1:0] diff;

   // Output selection
   ld_src_e           ld_src;
   logic [LED_W-1:0]  ld_nxt;

   // Register all inputs; keep the previous registered word for change detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            word_q[c]    <= '0;
            word_prev[c] <= '0;
         end
         auto_q   <= 1'b0;
         step_q   <= 1'b0;
         freeze_q <= 1'b0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            word_q[c]    <= {sel_in[c], seg_in[c*SEG_W +: SEG_W]};
            word_prev[c] <= word_q[c];
         end
         auto_q   <= auto_mode;
         step_q   <= step;
         freeze_q <= freeze;
      end
   end

   debug_dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_dwell (
      .clk(clk),
      .rst(rst),
      .en (auto_q),
      .clr(adv),
      .tc (dwell_tc)
   );

   // Step and dwell expiry merge into one advance, so coincident events move
   // the index by one only.
   always_comb begin
      adv     = step_q | dwell_tc;
      idx_nxt = (ch_idx == IDX_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         diff[c]        = (word_q[c] != word_prev[c]);
         // A fresh change outranks the clear from entering the channel.
         changed_nxt[c] = diff[c] |
                          (changed[c] & ~(adv && (idx_nxt == IDX_W'(c))));
      end
   end

   // Index, sticky change bits and the entry-time change flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_idx  <= '0;
         chg     <= 1'b0;
         changed <= '0;
      end else begin
         if (adv) begin
            ch_idx <= idx_nxt;
            chg    <= changed[idx_nxt];
         end
         changed <= changed_nxt;
      end
   end

   // On the rise cycle the snapshot is still being written, so the live word
   // (which is exactly what gets captured) is forwarded instead.
   always_comb begin
      freeze_rise = freeze_q & ~freeze_d;
      ld_src      = (freeze_q && !freeze_rise) ? SRC_SNAP : SRC_LIVE;
      ld_nxt      = (ld_src == SRC_SNAP) ? snap[ch_idx] : word_q[ch_idx];
   end

   // Snapshot capture on the freeze rise and the registered LED output.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            snap[c] <= '0;
         end
         freeze_d <= 1'b0;
         LD       <= BLANK_PATTERN[LED_W-1:0];
      end else begin
         if (freeze_rise) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
               snap[c] <= word_q[c];
            end
         end
         freeze_d <= freeze_q;
         LD       <= ld_nxt;
      end
   end

endmodule

// File: tb/tb_debug_led_scanner.sv
// Directed bench for debug_led_scanner with a due-cycle scoreboard:
// expectations are queued when stimulus is applied and checked when due.
module tb_debug_led_scanner;

   localparam int NUM_CH = 4;
   localparam int SEG_W  = 7;
   localparam int DWELL  = 4;

   localparam int K_LD  = 0;
   localparam int K_IDX = 1;
   localparam int K_CHG = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [27:0] seg_in;
   logic [3:0]  sel_in;
   logic        auto_mode;
   logic        step;
   logic        freeze;
   logic [7:0]  LD;
   logic [1:0]  ch_idx;
   logic        chg;

   always #5 clk = ~clk;

   debug_led_scanner #(
      .NUM_CH      (NUM_CH),
      .SEG_W       (SEG_W),
      .DWELL_CYCLES(DWELL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seg_in   (seg_in),
      .sel_in   (sel_in),
      .auto_mode(auto_mode),
      .step     (step),
      .freeze   (freeze),
      .LD       (LD),
      .ch_idx   (ch_idx),
      .chg      (chg)
   );

   typedef struct {
      int         due;
      int         kind;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] old_w0;
   logic [7:0] old_w2;

   function automatic logic [7:0] word(input int c);
      return {sel_in[c], seg_in[c*7 +: 7]};
   endfunction

   // Expected index in auto mode, t cycles after reset release.
   function automatic int auto_idx(input int t);
      return (t <= 4) ? 0 : (((t - 5) / 4) + 1) % 4;
   endfunction

   task automatic exp_at(input int delay, input int kind, input logic [7:0] val,
                         input string tag);
      exp_t e;
      e.due  = cyc + delay;
      e.kind = kind;
      e.val  = val;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      logic [7:0] obs;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            case (sb[i].kind)
               K_LD:    obs = LD;
               K_IDX:   obs = {6'b0, ch_idx};
               default: obs = {7'b0, chg};
            endcase
            checks++;
            assert (obs === sb[i].val)
            else begin
               errors++;
               $error("FAIL %s cyc=%0d observed=%h expected=%h",
                      sb[i].tag, cyc, obs, sb[i].val);
            end
            sb.delete(i);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_at(1, K_LD,  8'h00, "rst_ld");
      exp_at(1, K_IDX, 8'h00, "rst_idx");
      exp_at(1, K_CHG, 8'h00, "rst_chg");
      tick();
      rst = 1'b0;
   endtask

   task automatic do_step(input int idx, input logic c);
      step = 1'b1;
      exp_at(2, K_IDX, 8'(idx), "step_idx");
      exp_at(2, K_CHG, {7'b0, c}, "step_chg");
      tick();
      step = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      auto_mode = 1'b0;
      step      = 1'b0;
      freeze    = 1'b0;
      seg_in    = {7'h4F, 7'h5B, 7'h06, 7'h3F};
      sel_in    = 4'b0101;
      repeat (3) tick();

      // Auto scan: 0,1,2,3,0 with four cycles per channel.
      do_reset();
      auto_mode = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         exp_at(t, K_IDX, 8'(auto_idx(t)), "auto_idx");
         if (t >= 2) exp_at(t, K_LD, word(auto_idx(t - 1)), "auto_ld");
      end
      repeat (20) tick();

      // Manual stepping with wrap; index stays put between pulses.
      do_reset();
      auto_mode = 1'b0;
      repeat (2) tick();
      for (int i = 1; i <= 4; i++) begin
         step = 1'b1;
         exp_at(2, K_IDX, 8'(i % 4), "man_idx");
         exp_at(6, K_IDX, 8'(i % 4), "man_hold");
         exp_at(3, K_LD, word(i % 4), "man_ld");
         tick();
         step = 1'b0;
         repeat (4) tick();
      end
      repeat (3) tick();

      // Step coincident with dwell terminal count.
      do_reset();
      auto_mode = 1'b1;
      repeat (3) tick();
      step = 1'b1;
      exp_at(2, K_IDX, 8'd1, "sim_idx");
      exp_at(5, K_IDX, 8'd1, "sim_restart_hold");
      exp_at(6, K_IDX, 8'd2, "sim_restart_adv");
      exp_at(3, K_LD, word(1), "sim_ld");
      tick();
      step = 1'b0;
      repeat (7) tick();
      auto_mode = 1'b0;

      // Freeze snapshot of ch2 = 5B, then live 06 after release.
      do_reset();
      repeat (2) tick();
      old_w0 = word(0);
      old_w2 = word(2);
      freeze = 1'b1;
      tick();
      exp_at(1, K_LD, old_w0, "frz_rise_ld");
      exp_at(2, K_LD, old_w0, "frz_hold_ld");
      seg_in[0 +: 7]  = 7'h7F;
      seg_in[14 +: 7] = 7'h06;
      tick();
      step = 1'b1;
      exp_at(2, K_IDX, 8'd1, "frz_step1");
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      exp_at(2, K_IDX, 8'd2, "frz_step2");
      exp_at(3, K_LD, old_w2, "frz_ch2_snap");
      exp_at(5, K_LD, old_w2, "frz_ch2_snap_hold");
      tick();
      step = 1'b0;
      repeat (4) tick();
      freeze = 1'b0;
      exp_at(1, K_LD, old_w2, "unfrz_lag");
      exp_at(2, K_LD, {1'b1, 7'h06}, "unfrz_live");
      repeat (3) tick();

      // Change flag: first lap clears the post-reset flags.
      do_reset();
      repeat (3) tick();
      do_step(1, 1'b1);
      do_step(2, 1'b1);
      do_step(3, 1'b1);
      do_step(0, 1'b1);
      do_step(1, 1'b0);
      seg_in[21 +: 7] = 7'h30;
      repeat (3) tick();
      do_step(2, 1'b0);
      do_step(3, 1'b1);
      do_step(0, 1'b0);
      do_step(1, 1'b0);
      do_step(2, 1'b0);
      do_step(3, 1'b0);

      // Reset at ch2 while frozen, freeze kept high through reset.
      do_reset();
      repeat (3) tick();
      do_step(1, 1'b1);
      do_step(2, 1'b1);
      freeze = 1'b1;
      repeat (3) tick();
      do_reset();
      exp_at(1, K_LD, 8'h00, "post_rst_ld");
      exp_at(2, K_LD, word(0), "post_rst_recapture");
      exp_at(4, K_LD, word(0), "post_rst_frozen");
      repeat (5) tick();
      do_step(1, 1'b1);
      freeze = 1'b0;
      repeat (4) tick();

      checks++;
      assert (sb.size() == 0)
      else begin
         errors++;
         $error("FAIL drain observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
